seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter N, default 16: width of the display value; SHALL be a multiple of 4, 4 <= N <= 32; D = N/4 digits.
REQ-002 Parameter COUNT_MAX, default 100000: clk cycles each digit is lit; SHALL be >= 1.
REQ-003 Parameter BLANK_LZ, default 0: 1 enables leading-zero blanking.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ToDisplay  input  N  value to show in hex, supplied by the display-select mux stage.
REQ-007 Enable  input  1  1 = display on, 0 = all digits dark.
REQ-008 Segments  output  7  active-low cathodes; bit0 = a ... bit6 = g.
REQ-009 Anodes  output  8  active-low digit enables; bit i = digit i, digit 0 = least significant nibble.
REQ-010 DP  output  1  active-low decimal point; held constant 1.

Function
REQ-011 Refresh counter SHALL count 0..COUNT_MAX-1 and wrap to 0; tick = counter at COUNT_MAX-1 (tick every cycle if COUNT_MAX = 1).
REQ-012 Digit index SHALL advance by 1 on each tick and wrap from D-1 to 0.
REQ-013 Snapshot register SHALL load ToDisplay only on a tick with index = D-1 (frame boundary); mid-frame ToDisplay changes SHALL NOT alter displayed digits.
REQ-014 Segments and Anodes SHALL be registered: they reflect the current index and snapshot with 1-cycle latency.
REQ-015 Lit digit: Anodes[index] = 0; all other Anodes bits = 1; Anodes[7:D] SHALL always be 1.
REQ-016 Segments for lit digit SHALL encode snapshot nibble [4*index+3:4*index]: 0=40h 1=79h 2=24h 3=30h 4=19h 5=12h 6=02h 7=78h 8=00h 9=10h A=08h b=03h C=46h d=21h E=06h F=0Eh.
REQ-017 Enable = 0: Anodes = FFh and Segments = 7Fh from the next cycle; counter, index and snapshot keep running.
REQ-018 BLANK_LZ = 1: digit i > 0 SHALL be dark (Anodes all 1, Segments = 7Fh) when snapshot nibbles i..D-1 are all zero; digit 0 is never blanked.
REQ-019 BLANK_LZ = 0: every digit 0..D-1 SHALL be lit in turn, zeros included.
REQ-020 Digit dwell: each digit SHALL stay lit exactly COUNT_MAX cycles; full frame = D*COUNT_MAX cycles.

Reset
REQ-021 While reset = 1: counter = 0, index = 0, snapshot = 0, Anodes = FFh, Segments = 7Fh, DP = 1.
REQ-022 Reset asserted mid-frame SHALL take priority over tick, snapshot load and Enable on the same edge.
REQ-023 First cycle after reset release: Anodes = FEh, Segments = 40h (digit 0 shows '0' from zero snapshot) if Enable = 1; snapshot takes ToDisplay at the first frame boundary.

Verification (N=16, COUNT_MAX=4 unless stated)
REQ-024 Reset held 2 cycles -> Anodes=FFh, Segments=7Fh, DP=1; one cycle after release -> Anodes=FEh, Segments=40h.
REQ-025 ToDisplay=1234h held across a frame boundary -> FEh/19h, FDh/30h, FBh/24h, F7h/79h, each exactly 4 cycles, then repeats.
REQ-026 ToDisplay 1234h -> ABCDh while index=1 -> digits 1..3 still show 3,2,1; next frame shows FEh/21h, FDh/46h, FBh/03h, F7h/08h.
REQ-027 Enable 1->0 mid-frame -> Anodes=FFh, Segments=7Fh next cycle; Enable back to 1 -> digit lit matches uninterrupted index sequence.
REQ-028 BLANK_LZ=1: ToDisplay=0000h -> only FEh/40h lit, digits 1..3 dark; ToDisplay=00A0h -> digit0 40h, digit1 08h, digits 2..3 dark.
REQ-029 COUNT_MAX=1, reset asserted during digit 2 -> next cycle outputs FFh/7Fh; after release, scan restarts at digit 0 with snapshot 0.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed hex display driver: scans D = N/4 digits, each lit for COUNT_MAX
// clocks, with frame-synchronous value capture and optional leading-zero blanking.
module seven_seg_scan_driver #(
  parameter int N         = 16,
  parameter int COUNT_MAX = 100000,
  parameter bit BLANK_LZ  = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] ToDisplay,
  input  logic         Enable,
  output logic [6:0]   Segments,
  output logic [7:0]   Anodes,
  output logic         DP
);

  localparam int D  = N / 4;
  localparam int CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_MAX - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(D - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [CW-1:0] r_count;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_snap;

  logic          w_tick;
  logic          w_frame_end;
  logic [3:0]    w_nib;
  logic          w_lz;
  logic          w_dark;
  logic [7:0]    w_anodes;

  assign w_tick      = (r_count == CNT_LAST);
  assign w_frame_end = w_tick && (r_idx == IDX_LAST);
  assign DP          = 1'b1;

  // Nibble of the current digit, and whether it is a blankable leading zero
  // (everything from this digit upward is zero; digit 0 never qualifies).
  always_comb begin
    w_nib = 4'h0;
    w_lz  = 1'b0;
    for (int i = 0; i < D; i++) begin
      w_nib = (r_idx == IW'(i)) ? r_snap[4*i +: 4] : w_nib;
      w_lz  = (r_idx == IW'(i)) ? ((i != 0) && ((r_snap >> (4*i)) == {N{1'b0}})) : w_lz;
    end
  end

  // One-hot active-low digit enable; digits above D-1 stay dark.
  always_comb begin
    w_anodes = 8'hFF;
    for (int i = 0; i < D; i++) begin
      w_anodes[i] = (r_idx == IW'(i)) ? 1'b0 : 1'b1;
    end
  end

  assign w_dark = !Enable || (BLANK_LZ && w_lz);

  // Refresh counter, digit index, frame snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_idx    <= '0;
      r_snap   <= '0;
      Anodes   <= 8'hFF;
      Segments <= 7'h7F;
    end else begin
      r_count <= w_tick ? '0 : r_count + CW'(1);
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end
      if (w_frame_end) begin
        r_snap <= ToDisplay;
      end
      Anodes   <= w_dark ? 8'hFF : w_anodes;
      Segments <= w_dark ? 7'h7F : hex_to_seg(w_nib);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench: three instances (plain, leading-zero blanking, one-cycle dwell)
// driven by a linear step sequence with hand-computed expected outputs.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_c, enable;
  logic [15:0] td_a, td_b, td_c;
  logic [6:0]  seg_a, seg_b, seg_c;
  logic [7:0]  an_a, an_b, an_c;
  logic        dp_a, dp_b, dp_c;

  int checks = 0;
  int errors = 0;
  int k;
  int d;
  logic [7:0] ea, eb;
  logic [6:0] esa, esb;

  logic [7:0] an_tab [4]   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
  logic [6:0] seg1234 [4]  = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] segABCD [4]  = '{7'h21, 7'h46, 7'h03, 7'h08};
  logic [7:0] c_an [10]    = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF,
                               8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFE};
  logic [6:0] c_seg [10]   = '{7'h00, 7'h78, 7'h02, 7'h7F, 7'h7F,
                               7'h40, 7'h40, 7'h40, 7'h40, 7'h00};

  seven_seg_scan_driver #(.N(16), .COUNT_MAX(4), .BLANK_LZ(1'b0)) u_a (
    .clk(clk), .reset(reset), .ToDisplay(td_a), .Enable(enable),
    .Segments(seg_a), .Anodes(an_a), .DP(dp_a));

  seven_seg_scan_driver #(.N(16), .COUNT_MAX(4), .BLANK_LZ(1'b1)) u_b (
    .clk(clk), .reset(reset), .ToDisplay(td_b), .Enable(enable),
    .Segments(seg_b), .Anodes(an_b), .DP(dp_b));

  seven_seg_scan_driver #(.N(16), .COUNT_MAX(1), .BLANK_LZ(1'b0)) u_c (
    .clk(clk), .reset(reset_c), .ToDisplay(td_c), .Enable(enable),
    .Segments(seg_c), .Anodes(an_c), .DP(dp_c));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
    k++;
  endtask

  initial begin
    reset   = 1'b1;
    reset_c = 1'b1;
    enable  = 1'b1;
    td_a    = 16'h0000;
    td_b    = 16'h0000;
    td_c    = 16'h5678;
    k       = -3;
    cyc();
    cyc();
    chk("rst_an_a",  an_a, 8'hFF);
    chk("rst_seg_a", {1'b0, seg_a}, 8'h7F);
    chk("rst_dp_a",  {7'h00, dp_a}, 8'h01);
    chk("rst_an_b",  an_b, 8'hFF);
    chk("rst_seg_b", {1'b0, seg_b}, 8'h7F);
    chk("rst_dp_b",  {7'h00, dp_b}, 8'h01);
    reset   = 1'b0;
    reset_c = 1'b0;
    td_a    = 16'h1234;

    // Edge k after release shows digit (k/4)%4 of the snapshot taken at the
    // last frame boundary (k = 15, 31, 47, ...).
    for (int i = 0; i < 76; i++) begin
      cyc();
      d = (k / 4) % 4;
      if (k >= 66 && k <= 69) begin
        ea = 8'hFF; esa = 7'h7F; eb = 8'hFF; esb = 7'h7F;
      end else begin
        ea  = an_tab[d];
        esa = (k < 16) ? 7'h40 : ((k < 48) ? seg1234[d] : segABCD[d]);
        if (k < 32) begin
          eb  = (d == 0) ? 8'hFE : 8'hFF;
          esb = (d == 0) ? 7'h40 : 7'h7F;
        end else begin
          case (d)
            0:       begin eb = 8'hFE; esb = 7'h40; end
            1:       begin eb = 8'hFD; esb = 7'h08; end
            default: begin eb = 8'hFF; esb = 7'h7F; end
          endcase
        end
      end
      chk("scan_an_a",  an_a, ea);
      chk("scan_seg_a", {1'b0, seg_a}, {1'b0, esa});
      chk("blank_an_b",  an_b, eb);
      chk("blank_seg_b", {1'b0, seg_b}, {1'b0, esb});
      if (k == 16) td_b   = 16'h00A0;
      if (k == 36) td_a   = 16'hABCD;
      if (k == 65) enable = 1'b0;
      if (k == 69) enable = 1'b1;
    end

    // One-cycle dwell instance: reset during digit 2, then restart from zero.
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("c_an",  an_c, c_an[i]);
      chk("c_seg", {1'b0, seg_c}, {1'b0, c_seg[i]});
      chk("c_dp",  {7'h00, dp_c}, 8'h01);
      if (i == 2) reset_c = 1'b1;
      if (i == 4) reset_c = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
